blink_ctrl: RTL and testbench

//   Command-driven LED blink sequencer. Replaces the fixed 1 Hz divider.

---
 rtl/blink_ctrl.sv | 155 +++++++++++++++
 tb/tb_blink_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_ctrl.sv
// blink_ctrl: command-driven LED sequencer. Takes OFF / ON / BLINK / BURST
// commands over a valid/ready handshake and times each LED phase in whole
// ticks of an internal prescaler. Bursts run to completion and pulse o_done.
module blink_ctrl #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 8
) (
  input  logic                i_clk_100MHz,
  input  logic                i_rst_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_mode,
  input  logic [PERIOD_W-1:0] i_cmd_half_period,
  input  logic [COUNT_W-1:0]  i_cmd_count,
  output logic                o_led,
  output logic                o_busy,
  output logic                o_done
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLINK_HI,
    S_BLINK_LO,
    S_BURST_HI,
    S_BURST_LO
  } state_t;

  state_t                r_state;
  logic [PRE_W-1:0]      r_pre;
  logic [PERIOD_W-1:0]   r_tick;
  logic [PERIOD_W-1:0]   r_hMinus1;
  logic [COUNT_W-1:0]    r_count;
  logic [COUNT_W-1:0]    r_pulses;
  logic                  r_led;
  logic                  r_busy;
  logic                  r_ready;
  logic                  r_done;

  state_t                w_nextState;
  logic [PRE_W-1:0]      w_nextPre;
  logic [PERIOD_W-1:0]   w_nextTick;
  logic [COUNT_W-1:0]    w_nextPulses;
  logic                  w_nextDone;
  logic                  w_accept;
  logic                  w_preWrap;
  logic                  w_phaseEnd;
  logic                  w_timed;

  // Next-state logic: a new command wins over phase timing; otherwise the
  // prescaler/tick pair advances and the phase flips when both wrap together.
  always_comb begin
    w_nextState  = r_state;
    w_nextPre    = r_pre;
    w_nextTick   = r_tick;
    w_nextPulses = r_pulses;
    w_nextDone   = 1'b0;
    w_accept     = i_cmd_valid && r_ready;
    w_preWrap    = (r_pre == PRE_LAST);
    w_phaseEnd   = w_preWrap && (r_tick == r_hMinus1);
    w_timed      = (r_state inside {S_BLINK_HI, S_BLINK_LO, S_BURST_HI, S_BURST_LO});

    if (w_accept) begin
      w_nextPre    = '0;
      w_nextTick   = '0;
      w_nextPulses = '0;
      case (i_cmd_mode)
        2'd0: w_nextState = S_OFF;
        2'd1: w_nextState = S_ON;
        2'd2: w_nextState = S_BLINK_HI;
        default: begin
          if (i_cmd_count == '0) begin
            w_nextState = S_OFF;
            w_nextDone  = 1'b1;
          end else begin
            w_nextState = S_BURST_HI;
          end
        end
      endcase
    end else if (w_timed) begin
      if (w_preWrap) begin
        w_nextPre = '0;
        if (r_tick == r_hMinus1) begin
          w_nextTick = '0;
        end else begin
          w_nextTick = r_tick + PERIOD_W'(1);
        end
      end else begin
        w_nextPre = r_pre + PRE_W'(1);
      end

      if (w_phaseEnd) begin
        case (r_state)
          S_BLINK_HI: w_nextState = S_BLINK_LO;
          S_BLINK_LO: w_nextState = S_BLINK_HI;
          S_BURST_HI: begin
            w_nextState  = S_BURST_LO;
            w_nextPulses = r_pulses + COUNT_W'(1);
          end
          S_BURST_LO: begin
            if (r_pulses == r_count) begin
              w_nextState = S_OFF;
              w_nextDone  = 1'b1;
            end else begin
              w_nextState = S_BURST_HI;
            end
          end
          default: w_nextState = r_state;
        endcase
      end
    end
  end

  // State, counters, latched command fields and registered outputs; outputs
  // are derived from the next state so they change on the same edge.
  always_ff @(posedge i_clk_100MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_OFF;
      r_pre     <= '0;
      r_tick    <= '0;
      r_hMinus1 <= '0;
      r_count   <= '0;
      r_pulses  <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_pre    <= w_nextPre;
      r_tick   <= w_nextTick;
      r_pulses <= w_nextPulses;
      r_done   <= w_nextDone;
      if (w_accept) begin
        r_hMinus1 <= (i_cmd_half_period == '0) ? '0 : (i_cmd_half_period - PERIOD_W'(1));
        r_count   <= i_cmd_count;
      end
      r_led   <= (w_nextState inside {S_ON, S_BLINK_HI, S_BURST_HI});
      r_busy  <= (w_nextState inside {S_BLINK_HI, S_BLINK_LO, S_BURST_HI, S_BURST_LO});
      r_ready <= !(w_nextState inside {S_BURST_HI, S_BURST_LO});
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_led       = r_led;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_blink_ctrl.sv
// tb_blink_ctrl: directed scenarios plus random commands, compared every
// cycle against a timeline model (mode plus cycles since acceptance).
module tb_blink_ctrl;

  localparam int CLK_HZ   = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int PERIOD_W = 16;
  localparam int COUNT_W  = 8;

  logic                clock;
  logic                rstN;
  logic                cmdValid;
  logic                cmdReady;
  logic [1:0]          cmdMode;
  logic [PERIOD_W-1:0] cmdHalfPeriod;
  logic [COUNT_W-1:0]  cmdCount;
  logic                led;
  logic                busy;
  logic                done;

  int checkCount = 0;
  int errorCount = 0;

  int mMode;
  int mT;
  int mH;
  int mN;
  bit mEdge;

  blink_ctrl #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .PERIOD_W(PERIOD_W),
    .COUNT_W(COUNT_W)
  ) dut (
    .i_clk_100MHz(clock),
    .i_rst_n(rstN),
    .i_cmd_valid(cmdValid),
    .o_cmd_ready(cmdReady),
    .i_cmd_mode(cmdMode),
    .i_cmd_half_period(cmdHalfPeriod),
    .i_cmd_count(cmdCount),
    .o_led(led),
    .o_busy(busy),
    .o_done(done)
  );

  // Free-running clock, period 10 time units.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int burstTotal();
    return 2 * mN * mH * DIV;
  endfunction

  function automatic bit expLed();
    int pl;
    pl = mH * DIV;
    if (mMode == 1) return 1'b1;
    if (mMode == 2) return ((mT / pl) % 2) == 0;
    if (mMode == 3 && mT < burstTotal()) return ((mT / pl) % 2) == 0;
    return 1'b0;
  endfunction

  function automatic bit expBusy();
    if (mMode == 2) return 1'b1;
    if (mMode == 3 && mT < burstTotal()) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit expDone();
    return (mMode == 3) && (mT == burstTotal());
  endfunction

  function automatic bit expReady();
    if (!mEdge) return 1'b0;
    if (mMode == 3 && mT < burstTotal()) return 1'b0;
    return 1'b1;
  endfunction

  // Timeline model: remembers the accepted command and counts clock edges
  // since it was accepted; expected outputs follow from plain arithmetic.
  always @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      mMode <= 0;
      mT    <= 0;
      mH    <= 1;
      mN    <= 0;
      mEdge <= 1'b0;
    end else begin
      mEdge <= 1'b1;
      if (cmdValid && expReady()) begin
        mMode <= int'(cmdMode);
        mH    <= (cmdHalfPeriod == '0) ? 1 : int'(cmdHalfPeriod);
        mN    <= int'(cmdCount);
        mT    <= 0;
      end else if (mT < 1_000_000) begin
        mT <= mT + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge: all four outputs against the model.
  always @(negedge clock) begin
    checkOutput("modelLed", int'(led), int'(expLed()));
    checkOutput("modelBusy", int'(busy), int'(expBusy()));
    checkOutput("modelDone", int'(done), int'(expDone()));
    checkOutput("modelReady", int'(cmdReady), int'(expReady()));
  end

  // Presents one command for one cycle; returns at the falling edge right
  // after the accepting edge (cycle 0 of the new command).
  task automatic applyStimulus(input int mode, input int hp, input int cnt);
    cmdValid      = 1'b1;
    cmdMode       = 2'(mode);
    cmdHalfPeriod = PERIOD_W'(hp);
    cmdCount      = COUNT_W'(cnt);
    @(negedge clock);
    cmdValid = 1'b0;
  endtask

  initial begin
    rstN          = 1'b0;
    cmdValid      = 1'b0;
    cmdMode       = 2'd0;
    cmdHalfPeriod = '0;
    cmdCount      = '0;

    // Reset held three cycles, then released.
    repeat (3) @(negedge clock);
    checkOutput("resetReady", int'(cmdReady), 0);
    rstN = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("postResetLed", int'(led), 0);
    checkOutput("postResetBusy", int'(busy), 0);
    checkOutput("postResetDone", int'(done), 0);
    checkOutput("postResetReady", int'(cmdReady), 1);

    // BLINK with H=2: 20-cycle phases.
    applyStimulus(2, 2, 0);
    for (int t = 0; t < 60; t++) begin
      if (t == 0 || t == 19 || t == 40 || t == 59) checkOutput("blinkHigh", int'(led), 1);
      if (t == 20 || t == 39) checkOutput("blinkLow", int'(led), 0);
      if (t == 0) checkOutput("blinkBusy", int'(busy), 1);
      @(negedge clock);
    end

    // BURST H=1 N=3 preempts the blink; done at cycle 60.
    applyStimulus(3, 1, 3);
    for (int t = 0; t < 62; t++) begin
      if (t == 0 || t == 40) checkOutput("burstHigh", int'(led), 1);
      if (t == 10 || t == 50) checkOutput("burstLow", int'(led), 0);
      if (t == 30 || t == 59) checkOutput("burstReady", int'(cmdReady), 0);
      if (t == 59) checkOutput("burstNotDoneYet", int'(done), 0);
      if (t == 60) begin
        checkOutput("burstDone", int'(done), 1);
        checkOutput("burstDoneLed", int'(led), 0);
        checkOutput("burstDoneReady", int'(cmdReady), 1);
      end
      if (t == 61) checkOutput("burstDoneOnce", int'(done), 0);
      @(negedge clock);
    end

    // BURST with N=0: immediate done, LED stays low.
    applyStimulus(3, 1, 0);
    checkOutput("zeroBurstDone", int'(done), 1);
    checkOutput("zeroBurstLed", int'(led), 0);
    checkOutput("zeroBurstReady", int'(cmdReady), 1);
    @(negedge clock);
    checkOutput("zeroBurstDoneOnce", int'(done), 0);

    // BLINK with H=0 behaves as H=1; ON accepted mid high phase.
    applyStimulus(2, 0, 0);
    for (int t = 0; t < 25; t++) begin
      if (t == 9 || t == 20) checkOutput("blinkH0High", int'(led), 1);
      if (t == 10) checkOutput("blinkH0Low", int'(led), 0);
      @(negedge clock);
    end
    applyStimulus(1, 0, 0);
    for (int t = 0; t < 30; t++) begin
      if (t == 0 || t == 29) begin
        checkOutput("onLed", int'(led), 1);
        checkOutput("onBusy", int'(busy), 0);
      end
      @(negedge clock);
    end

    // Asynchronous reset in the middle of the second burst pulse.
    applyStimulus(3, 2, 3);
    repeat (45) @(negedge clock);
    checkOutput("preResetLed", int'(led), 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("asyncResetLed", int'(led), 0);
    checkOutput("asyncResetBusy", int'(busy), 0);
    checkOutput("asyncResetReady", int'(cmdReady), 0);
    repeat (2) @(negedge clock);
    rstN = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("afterResetLed", int'(led), 0);
    checkOutput("afterResetDone", int'(done), 0);
    checkOutput("afterResetBusy", int'(busy), 0);
    checkOutput("afterResetReady", int'(cmdReady), 1);

    // Random commands, including attempts to preempt bursts.
    for (int i = 0; i < 3000; i++) begin
      cmdValid      = ($urandom_range(0, 19) == 0);
      cmdMode       = 2'($urandom_range(0, 3));
      cmdHalfPeriod = PERIOD_W'($urandom_range(0, 3));
      cmdCount      = COUNT_W'($urandom_range(0, 3));
      @(negedge clock);
    end
    cmdValid = 1'b0;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
